// File: rtl/uart_rx_param_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART receiver.
//   rx_state_t : receiver FSM states
//   par_calc   : expected parity bit for a data word (odd=1 selects odd parity)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Callers zero-extend narrower words; zero bits do not change the XOR.
    function automatic logic par_calc(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: host/line side signals of the UART receiver.
//   rx         serial line (idle high)
//   read       pop strobe for the receive FIFO
//   rxdata     FIFO head word
//   rxrdy      FIFO non-empty
//   busy       receiver FSM not idle
//   frame_err, parity_err, overrun  single-cycle error pulses
// master: the receiver; slave: the host / line driver.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 read;
    logic [DATA_BITS-1:0] rxdata;
    logic                 rxrdy;
    logic                 busy;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        input  rx, read,
        output rxdata, rxrdy, busy, frame_err, parity_err, overrun
    );

    modport slave (
        output rx, read,
        input  rxdata, rxrdy, busy, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_rx_param_fifo.sv
// rx_fifo: first-word-fall-through receive FIFO.
//   clk, reset  clock, asynchronous active-high reset
//   push, wdata write strobe and word (honoured when full only with a simultaneous pop)
//   pop         read strobe (ignored when empty)
//   rdata       head word, combinational from storage; all 1s after reset
//   empty, full occupancy flags
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '1;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with optional parity, 1/2 stop bits
// and a small FWFT receive FIFO.
//   clk    OVERSAMPLE x baud clock
//   reset  asynchronous active-high reset
//   bus    uart_rx_param_if.master (rx, read in; rxdata, rxrdy, busy, error pulses out)
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_param_if.master bus
);
    localparam int             TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic           ODD       = (PARITY_ODD != 0);

    rx_state_t            state;
    logic                 sync1;
    logic                 rx_s;
    logic [TW-1:0]        tick;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    logic                 sample_pt;
    logic                 last_stop;
    logic                 parity_ok;
    logic                 word_good;
    logic                 pop;
    logic                 push;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign sample_pt = (tick == TICK_END);
    assign last_stop = (state == STOP) && sample_pt && (bit_cnt == LAST_STOP);
    assign parity_ok = (PARITY_EN == 0) || (pbit == par_calc(16'(shreg), ODD));
    // Good word: last stop bit high and parity fine; lands in the FIFO unless it is full
    // with no pop in the same cycle.
    assign word_good = last_stop && rx_s && parity_ok;
    assign pop       = bus.read && !fifo_empty;
    assign push      = word_good && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            pbit         <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= last_stop && rx_s && !parity_ok;
            overrun_q    <= word_good && fifo_full && !pop;
            case (state)
                IDLE: begin
                    tick    <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // Clearing tick at the half-bit point puts every later sample mid-bit.
                    if (tick == TICK_MID) begin
                        tick  <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_pt) begin
                        tick  <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                PARITY: begin
                    if (sample_pt) begin
                        tick  <= '0;
                        pbit  <= rx_s;
                        state <= STOP;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_pt) begin
                        tick <= '0;
                        if (!rx_s) begin
                            // First low stop sample ends the frame; wait out the line in BREAK.
                            frame_err_q <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= BREAK;
                        end else if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                BREAK: begin
                    tick <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rx_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata(shreg),
        .pop  (pop),
        .rdata(bus.rxdata),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign bus.rxrdy      = !fifo_empty;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param.
//   dut0: 8N1, OVERSAMPLE 16, FIFO depth 4
//   dut1: 8E2, OVERSAMPLE 8, FIFO depth 2
// Stimulus pushes expected words into per-DUT queues; a monitor pops and compares
// whenever the host reads a presented word, and counts error-pulse cycles.
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus1 ();

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(2), .FIFO_DEPTH(2)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    int checks = 0;
    int errors = 0;
    int fe0 = 0, pe0 = 0, ov0 = 0;
    int fe1 = 0, pe1 = 0, ov1 = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    logic [7:0] e0, e1;
    logic [7:0] words [5];

    // Monitor: sample away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus0.frame_err)  fe0++;
            if (bus0.parity_err) pe0++;
            if (bus0.overrun)    ov0++;
            if (bus1.frame_err)  fe1++;
            if (bus1.parity_err) pe1++;
            if (bus1.overrun)    ov1++;
            if (bus0.read && bus0.rxrdy) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL pop0_unexpected got %0h want none", bus0.rxdata);
                end else begin
                    e0 = exp0.pop_front();
                    if (bus0.rxdata !== e0) begin
                        errors++;
                        $display("FAIL pop0_word got %0h want %0h", bus0.rxdata, e0);
                    end
                end
            end
            if (bus1.read && bus1.rxrdy) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL pop1_unexpected got %0h want none", bus1.rxdata);
                end else begin
                    e1 = exp1.pop_front();
                    if (bus1.rxdata !== e1) begin
                        errors++;
                        $display("FAIL pop1_word got %0h want %0h", bus1.rxdata, e1);
                    end
                end
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // 8N1 frame on dut0; optionally pulse read on the cycle of the stop-bit sample edge.
    task automatic send0(input logic [7:0] d, input logic stop_v, input logic rd_at_stop);
        bus0.rx = 1'b0;
        tick_n(16);
        for (int i = 0; i < 8; i++) begin
            bus0.rx = d[i];
            tick_n(16);
        end
        bus0.rx = stop_v;
        for (int c = 0; c < 16; c++) begin
            if (rd_at_stop && c == 10) bus0.read = 1'b1;
            @(posedge clk);
            #2;
            bus0.read = 1'b0;
        end
    endtask

    // 8E2 frame on dut1 with an explicit parity bit.
    task automatic send1(input logic [7:0] d, input logic pb);
        bus1.rx = 1'b0;
        tick_n(8);
        for (int i = 0; i < 8; i++) begin
            bus1.rx = d[i];
            tick_n(8);
        end
        bus1.rx = pb;
        tick_n(8);
        bus1.rx = 1'b1;
        tick_n(16);
    endtask

    task automatic read0();
        bus0.read = 1'b1;
        tick_n(1);
        bus0.read = 1'b0;
    endtask

    task automatic read1();
        bus1.read = 1'b1;
        tick_n(1);
        bus1.read = 1'b0;
    endtask

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        bus0.rx = 1'b1; bus0.read = 1'b0;
        bus1.rx = 1'b1; bus1.read = 1'b0;
        reset = 1'b1;
        tick_n(3);
        check("rst_rxrdy", {31'd0, bus0.rxrdy}, 0);
        check("rst_rxdata", {24'd0, bus0.rxdata}, 32'hFF);
        check("rst_busy", {31'd0, bus0.busy}, 0);
        check("rst_pulses", {29'd0, bus0.frame_err, bus0.parity_err, bus0.overrun}, 0);
        reset = 1'b0;
        tick_n(4);

        // Parity: 0x07 has odd weight, so even parity needs pbit=1.
        exp1.push_back(8'h07);
        send1(8'h07, 1'b1);
        send1(8'h07, 1'b0);
        tick_n(4);
        check("par_err_cnt", pe1, 1);
        check("par_fe_cnt", fe1, 0);
        check("par_rxrdy", {31'd0, bus1.rxrdy}, 1);
        check("par_head", {24'd0, bus1.rxdata}, 32'h07);
        read1();
        check("par_empty", {31'd0, bus1.rxrdy}, 0);

        // Back-to-back 8N1 frames.
        exp0.push_back(8'hA5);
        exp0.push_back(8'h3C);
        send0(8'hA5, 1'b1, 1'b0);
        send0(8'h3C, 1'b1, 1'b0);
        tick_n(2);
        check("b2b_rxrdy", {31'd0, bus0.rxrdy}, 1);
        check("b2b_head", {24'd0, bus0.rxdata}, 32'hA5);
        read0();
        check("b2b_second", {24'd0, bus0.rxdata}, 32'h3C);
        read0();
        check("b2b_empty", {31'd0, bus0.rxrdy}, 0);
        check("b2b_no_err", fe0 + pe0 + ov0, 0);

        // Stop bit low then line held low for 3 bit-times.
        send0(8'h55, 1'b0, 1'b0);
        tick_n(48);
        check("brk_busy", {31'd0, bus0.busy}, 1);
        check("brk_fe_cnt", fe0, 1);
        bus0.rx = 1'b1;
        tick_n(4);
        check("brk_idle", {31'd0, bus0.busy}, 0);
        check("brk_nopush", {31'd0, bus0.rxrdy}, 0);
        tick_n(16);
        exp0.push_back(8'h12);
        send0(8'h12, 1'b1, 1'b0);
        tick_n(2);
        read0();
        check("after_brk_empty", {31'd0, bus0.rxrdy}, 0);

        // Quarter-bit glitch.
        bus0.rx = 1'b0;
        tick_n(4);
        check("glitch_busy", {31'd0, bus0.busy}, 1);
        bus0.rx = 1'b1;
        tick_n(7);
        check("glitch_idle", {31'd0, bus0.busy}, 0);
        check("glitch_nopush", {31'd0, bus0.rxrdy}, 0);
        check("glitch_fe_cnt", fe0, 1);
        check("glitch_pe_cnt", pe0, 0);

        // Overrun: fifth word dropped.
        tick_n(16);
        for (int i = 0; i < 4; i++) exp0.push_back(words[i]);
        for (int i = 0; i < 5; i++) send0(words[i], 1'b1, 1'b0);
        tick_n(2);
        check("ovr_cnt", ov0, 1);
        check("ovr_head", {24'd0, bus0.rxdata}, 32'h11);
        repeat (4) read0();
        check("ovr_empty", {31'd0, bus0.rxrdy}, 0);

        // Same, with a pop on the fifth word's stop sample.
        tick_n(16);
        for (int i = 0; i < 5; i++) exp0.push_back(words[i]);
        for (int i = 0; i < 4; i++) send0(words[i], 1'b1, 1'b0);
        send0(words[4], 1'b1, 1'b1);
        tick_n(2);
        check("pushpop_ovr_cnt", ov0, 1);
        check("pushpop_head", {24'd0, bus0.rxdata}, 32'h22);
        repeat (4) read0();
        check("pushpop_empty", {31'd0, bus0.rxrdy}, 0);

        // Reset mid-DATA of 0xFF with a word sitting in the FIFO.
        tick_n(16);
        exp0.push_back(8'h5A);
        send0(8'h5A, 1'b1, 1'b0);
        tick_n(2);
        check("pre_rst_rxrdy", {31'd0, bus0.rxrdy}, 1);
        bus0.rx = 1'b0;
        tick_n(16);
        bus0.rx = 1'b1;
        tick_n(48);
        check("pre_rst_busy", {31'd0, bus0.busy}, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_rxrdy", {31'd0, bus0.rxrdy}, 0);
        check("mid_rst_rxdata", {24'd0, bus0.rxdata}, 32'hFF);
        check("mid_rst_busy", {31'd0, bus0.busy}, 0);
        exp0.delete();
        tick_n(2);
        reset = 1'b0;
        tick_n(48);
        exp0.push_back(8'h81);
        send0(8'h81, 1'b1, 1'b0);
        tick_n(2);
        check("post_rst_head", {24'd0, bus0.rxdata}, 32'h81);
        read0();
        check("post_rst_empty", {31'd0, bus0.rxrdy}, 0);
        check("final_fe_cnt", fe0, 1);
        check("final_pe_cnt", pe0, 0);
        check("final_ov_cnt", ov0, 1);
        check("final_dut1_errs", fe1 + ov1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
